// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser for a mono synth voice: tracks running status and
// turns note-on/note-off messages on the selected channel into envelope pulses.
module midi_note_decoder #(
    parameter bit OMNI = 1'b0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [3:0] channel_sel,
    output logic       note_on,
    output logic       note_off,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       err_pulse
);

    localparam int unsigned DATA_W = 7;
    localparam int unsigned TYPE_W = 4;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_D1     = 2'd1,
        WAIT_D2     = 2'd2
    } state_t;

    state_t              state;
    logic                rs_valid;
    logic [TYPE_W-1:0]   rs_type;
    logic                rs_accept;
    logic [DATA_W-1:0]   d1;
    logic                sysex_on;
    logic [1:0]          sc_left;

    // Byte classification of the incoming byte
    logic is_rt_c;
    logic is_sc_c;
    logic is_ch_c;
    logic ch_accept_c;
    logic one_byte_c;

    always_comb begin
        is_rt_c     = (rx_data[7:3] == 5'b11111);
        is_sc_c     = (rx_data[7:3] == 5'b11110);
        is_ch_c     = rx_data[7] && (rx_data[7:4] != 4'hF);
        ch_accept_c = (rx_data[7:5] == 3'b100) && (OMNI || (rx_data[3:0] == channel_sel));
        one_byte_c  = (rs_type == 4'hC) || (rs_type == 4'hD);
    end

    // Parser state, running status and registered voice outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= WAIT_STATUS;
            rs_valid  <= 1'b0;
            rs_type   <= '0;
            rs_accept <= 1'b0;
            d1        <= '0;
            sysex_on  <= 1'b0;
            sc_left   <= 2'd0;
            note_on   <= 1'b0;
            note_off  <= 1'b0;
            note      <= '0;
            velocity  <= '0;
            gate      <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            note_on   <= 1'b0;
            note_off  <= 1'b0;
            err_pulse <= 1'b0;
            if (rx_valid && !is_rt_c) begin
                if (is_ch_c) begin
                    rs_valid  <= 1'b1;
                    rs_type   <= rx_data[7:4];
                    rs_accept <= ch_accept_c;
                    sysex_on  <= 1'b0;
                    sc_left   <= 2'd0;
                    state     <= WAIT_D1;
                end else if (is_sc_c) begin
                    // SysEx swallows data until EOX; F1/F3/F2 carry 1/1/2 data bytes
                    rs_valid  <= 1'b0;
                    rs_accept <= 1'b0;
                    state     <= WAIT_STATUS;
                    sysex_on  <= (rx_data == 8'hF0);
                    if ((rx_data == 8'hF1) || (rx_data == 8'hF3)) begin
                        sc_left <= 2'd1;
                    end else if (rx_data == 8'hF2) begin
                        sc_left <= 2'd2;
                    end else begin
                        sc_left <= 2'd0;
                    end
                end else begin
                    case (state)
                        WAIT_STATUS, WAIT_D1: begin
                            if (rs_valid) begin
                                d1    <= rx_data[6:0];
                                state <= one_byte_c ? WAIT_STATUS : WAIT_D2;
                            end else if (sysex_on) begin
                                state <= WAIT_STATUS;
                            end else if (sc_left != 2'd0) begin
                                sc_left <= sc_left - 2'd1;
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end
                        WAIT_D2: begin
                            state <= WAIT_STATUS;
                            if (rs_accept) begin
                                if ((rs_type == 4'h9) && (rx_data[6:0] != 7'd0)) begin
                                    note_on  <= 1'b1;
                                    note     <= d1;
                                    velocity <= rx_data[6:0];
                                    gate     <= 1'b1;
                                end else if (gate && (d1 == note)) begin
                                    note_off <= 1'b1;
                                    gate     <= 1'b0;
                                end
                            end
                        end
                        default: state <= WAIT_STATUS;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/midi_note_decoder.md
MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

Interface
REQ-001 Parameter OMNI, default 0, meaning 1 = accept all channels and ignore channel_sel.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_b  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  received MIDI byte from the UART.
REQ-005 rx_valid  input  1  rx_data valid; one byte consumed per cycle with rx_valid=1.
REQ-006 channel_sel  input  4  MIDI channel to accept when OMNI=0.
REQ-007 note_on  output  1  one-cycle pulse; drives the envelope generator note_on.
REQ-008 note_off  output  1  one-cycle pulse; drives the envelope generator note_off.
REQ-009 note  output  7  number of the currently or last held note.
REQ-010 velocity  output  7  velocity of the last accepted note-on.
REQ-011 gate  output  1  high while a note is held.
REQ-012 err_pulse  output  1  one-cycle pulse on an orphan data byte.

Function
REQ-013 Byte classes SHALL be decoded as follows: data 0x00-0x7F; channel status 0x80-0xEF; system common 0xF0-0xF7; real-time 0xF8-0xFF.
REQ-014 The parser SHALL use three states: WAIT_STATUS, WAIT_D1 and WAIT_D2.
REQ-015 A real-time byte SHALL be ignored in every state, with no change to state, running status or outputs.
REQ-016 A channel status byte SHALL be latched as running status and SHALL move the parser to WAIT_D1 from any state.
REQ-017 The latched channel status SHALL be marked accepted only if its type is 0x8 or 0x9 and its channel equals channel_sel (or OMNI=1).
REQ-018 A status byte arriving in WAIT_D1 or WAIT_D2 SHALL abandon the partial message with no event and no err_pulse.
REQ-019 Message length SHALL be one data byte for types 0xC and 0xD and two data bytes for all other types.
REQ-020 Data bytes of non-accepted messages SHALL be consumed per their length without generating any event.
REQ-021 A system common byte SHALL invalidate running status and move the parser to WAIT_STATUS.
REQ-022 Data bytes following a system common byte, including the SysEx payload, SHALL be discarded silently.
REQ-023 In WAIT_STATUS with running status valid, a data byte SHALL be treated as D1 of a new message of the running type.
REQ-024 In WAIT_STATUS with running status invalid, a data byte SHALL be dropped and SHALL assert err_pulse for one cycle, unless the drop is covered by REQ-022.
REQ-025 After the final data byte, the parser SHALL return to WAIT_STATUS with running status retained.
REQ-026 An accepted type-0x9 message with D2!=0 SHALL, in the cycle after D2 is sampled, pulse note_on and load note<=D1, velocity<=D2 and gate<=1.
REQ-027 A note-on SHALL retrigger when gate is already 1, replacing note (mono, last-note priority).
REQ-028 An accepted type-0x8 message, or type-0x9 with D2=0, SHALL pulse note_off and clear gate only if gate=1 and D1 equals note; otherwise it SHALL be ignored.
REQ-029 A note-off SHALL leave note and velocity unchanged.
REQ-030 note_on and note_off SHALL never be high in the same cycle.
REQ-031 All outputs SHALL be registered, with a latency of exactly 1 cycle from the final data byte to the pulse.
REQ-032 Cycles with rx_valid=0 SHALL change nothing, and all pulses SHALL deassert after one cycle.

Reset
REQ-033 When rst_b=0, the block SHALL asynchronously clear note_on, note_off, gate and err_pulse to 0, note to 0, velocity to 0, the state to WAIT_STATUS and running status to invalid.
REQ-034 Reset asserted mid-message SHALL discard the partial message.
REQ-035 The first byte after reset release SHALL be handled under REQ-024 (a data byte produces err_pulse).

Verification
REQ-036 Bytes 0x90,0x3C,0x64 on channel_sel=0 -> note_on pulse 1 cycle after 0x64; note=0x3C, velocity=0x64, gate=1.
REQ-037 Bytes 0x90,0x3C,0x64 then running status 0x3C,0x00 -> second message gives a note_off pulse and gate=0; 0x40,0x50 then gives note_on with note=0x40.
REQ-038 Held note 0x40 then 0x80,0x3C,0x00 -> no pulse and gate stays 1; then 0x80,0x40,0x00 -> note_off pulse.
REQ-039 Bytes 0x90,0x3C,0xF8,0x64 -> note_on as in REQ-036, with the real-time byte ignored; bytes 0x91,0x3C,0x64 with OMNI=0 -> no event, while OMNI=1 -> note_on.
REQ-040 Reset release then data 0x3C -> err_pulse; bytes 0xF0,0x01,0x02,0xF7,0x3C -> no err_pulse for 0x01 or 0x02, err_pulse for 0x3C, and no note event.
REQ-041 Bytes 0x90,0x3C then 0xB0,0x07,0x7F -> no event and no err_pulse; rst_b low during 0x90,0x3C -> all outputs 0.
